// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// State encoding and width helpers live here.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RELEASE = 3'd1,
    RUN     = 3'd2,
    SWRST   = 3'd3,
    ACK     = 3'd4
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter width: clog2 with a floor of one bit.
  function automatic int cw(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Async-assert / sync-deassert flop chain.
// Each stage is a library reset flop shifting in 1.
module rst_sync #(
  parameter int SYNC = 2
) (
  input  logic ck,
  input  logic nrst,
  output logic q
);

  logic [SYNC-1:0] sync_q;

  // Shift a constant 1 through the chain once nrst is high.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], 1'b1};
    end
  end

  assign q = sync_q[SYNC-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: staggered domain release plus a
// four-phase software-reset handshake.
module rst_seq #(
  parameter int NDOM = 3,
  parameter int SYNC = 2,
  parameter int DLY  = 4
) (
  input  logic            ck,
  input  logic            nrst,
  input  logic            swrst_req,
  output logic            swrst_ack,
  output logic [NDOM-1:0] dom_nrst,
  output logic            ready
);

  import rst_seq_pkg::*;

  localparam int CW = cw(DLY);
  localparam int IW = cw(NDOM);

  localparam logic [CW-1:0] CNT_LAST = CW'(DLY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDOM - 1);

  logic            sync_rel;
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   idx_q;
  logic [NDOM-1:0] dom_q;
  logic            ready_q;
  logic            ack_q;
  logic            cnt_end;
  logic            idx_end;
  logic [CW-1:0]   cnt_d;

  rst_sync #(
    .SYNC (SYNC)
  ) u_sync (
    .ck   (ck),
    .nrst (nrst),
    .q    (sync_rel)
  );

  // Terminal-count decode and the incremented count.
  always_comb begin
    cnt_end = (cnt_q == CNT_LAST);
    idx_end = (idx_q == IDX_LAST);
    cnt_d   = cnt_q + 1'b1;
  end

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (sync_rel) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        RELEASE: begin
          if (cnt_end) begin
            for (int k = 0; k < NDOM; k++) begin
              if (idx_q == IW'(k)) dom_q[k] <= 1'b1;
            end
            cnt_q <= '0;
            if (idx_end) begin
              idx_q   <= '0;
              ready_q <= 1'b1;
              state_q <= RUN;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RUN: begin
          if (swrst_req) begin
            dom_q   <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= SWRST;
          end
        end
        SWRST: begin
          if (cnt_end) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ACK: begin
          if (!swrst_req) begin
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= RELEASE;
          end
        end
        default: begin
          state_q <= HOLD;
          dom_q   <= '0;
          ready_q <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dom_nrst  = dom_q;
  assign ready     = ready_q;
  assign swrst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default instance
// plus NDOM=1/DLY=1 and NDOM=8/DLY=16 corners.
module tb_rst_seq;

  logic       ck;
  logic       nrst;
  logic       req;
  logic       zreq;
  logic       ack;
  logic [2:0] dom;
  logic       rdy;
  logic       c1_ack;
  logic [0:0] c1_dom;
  logic       c1_rdy;
  logic       c8_ack;
  logic [7:0] c8_dom;
  logic       c8_rdy;

  int compared;
  int mismatched;

  rst_seq #(.NDOM(3), .SYNC(2), .DLY(4)) dut (
    .ck        (ck),
    .nrst      (nrst),
    .swrst_req (req),
    .swrst_ack (ack),
    .dom_nrst  (dom),
    .ready     (rdy)
  );

  rst_seq #(.NDOM(1), .SYNC(2), .DLY(1)) dut_c1 (
    .ck        (ck),
    .nrst      (nrst),
    .swrst_req (zreq),
    .swrst_ack (c1_ack),
    .dom_nrst  (c1_dom),
    .ready     (c1_rdy)
  );

  rst_seq #(.NDOM(8), .SYNC(2), .DLY(16)) dut_c8 (
    .ck        (ck),
    .nrst      (nrst),
    .swrst_req (zreq),
    .swrst_ack (c8_ack),
    .dom_nrst  (c8_dom),
    .ready     (c8_rdy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  function automatic logic [2:0] exp_dom(input int e);
    if (e >= 12) return 3'b111;
    if (e >= 8)  return 3'b011;
    if (e >= 4)  return 3'b001;
    return 3'b000;
  endfunction

  // Hold nrst low three cycles, release just after an edge.
  task automatic do_reset;
    nrst = 1'b0;
    repeat (3) tick;
    nrst = 1'b1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    req  = 1'b0;
    zreq = 1'b0;
    #2;
    compared++;
    if (dom !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_dom got=%b exp=000", dom);
    end
    compared++;
    if (rdy !== 1'b0 || ack !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_rdy_ack got=%b%b exp=00", rdy, ack);
    end
    compared++;
    if (c1_dom !== 1'b0 || c8_dom !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_corner got=%b/%h exp=0/00",
               c1_dom, c8_dom);
    end
  endtask

  // Checks edges t0..t0+14 of a default-parameter release.
  task automatic check_release(input string tag);
    logic [2:0] e_dom;
    for (int e = 0; e <= 14; e++) begin
      tick;
      e_dom = exp_dom(e - 2);
      compared++;
      if (dom !== e_dom) begin
        mismatched++;
        $display("FAIL %s_dom edge=%0d got=%b exp=%b",
                 tag, e, dom, e_dom);
      end
      compared++;
      if (rdy !== (e >= 14)) begin
        mismatched++;
        $display("FAIL %s_ready edge=%0d got=%b exp=%b",
                 tag, e, rdy, (e >= 14));
      end
      compared++;
      if (ack !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_ack edge=%0d got=%b exp=0",
                 tag, e, ack);
      end
    end
  endtask

  task automatic test_powerup;
    do_reset;
    check_release("powerup");
  endtask

  task automatic test_async_mid;
    do_reset;
    for (int e = 0; e <= 10; e++) tick;
    compared++;
    if (dom !== 3'b011) begin
      mismatched++;
      $display("FAIL async_pre got=%b exp=011", dom);
    end
    nrst = 1'b0;
    #1;
    compared++;
    if (dom !== 3'b000 || rdy !== 1'b0) begin
      mismatched++;
      $display("FAIL async_drop got=%b/%b exp=000/0", dom, rdy);
    end
    repeat (2) tick;
    nrst = 1'b1;
    check_release("rerelease");
  endtask

  // Assumes the default instance has just entered RUN.
  task automatic check_swrst_release(input string tag);
    logic [2:0] e_dom;
    for (int i = 1; i <= 12; i++) begin
      tick;
      e_dom = exp_dom(i);
      compared++;
      if (dom !== e_dom || rdy !== (i >= 12) || ack !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_rel F+%0d got=%b/%b/%b exp=%b/%b/0",
                 tag, i, dom, rdy, ack, e_dom, (i >= 12));
      end
    end
  endtask

  task automatic test_swrst;
    req = 1'b1;
    tick;
    compared++;
    if (dom !== 3'b000 || rdy !== 1'b0 || ack !== 1'b0) begin
      mismatched++;
      $display("FAIL swrst_enter got=%b/%b/%b exp=000/0/0",
               dom, rdy, ack);
    end
    for (int i = 1; i <= 4; i++) begin
      tick;
      compared++;
      if (ack !== (i == 4) || dom !== 3'b000) begin
        mismatched++;
        $display("FAIL swrst_ack E+%0d got=%b/%b exp=%b/000",
                 i, ack, dom, (i == 4));
      end
    end
    req = 1'b0;
    tick;
    compared++;
    if (ack !== 1'b0 || dom !== 3'b000) begin
      mismatched++;
      $display("FAIL swrst_ackdrop got=%b/%b exp=0/000", ack, dom);
    end
    check_swrst_release("swrst");
  endtask

  task automatic test_req_during_release;
    do_reset;
    for (int e = 0; e <= 14; e++) begin
      req = ((e >= 7 && e <= 12) || e >= 14);
      tick;
      compared++;
      if (dom !== exp_dom(e - 2) || rdy !== (e >= 14)) begin
        mismatched++;
        $display("FAIL reqrel edge=%0d got=%b/%b exp=%b/%b",
                 e, dom, rdy, exp_dom(e - 2), (e >= 14));
      end
    end
    tick;
    compared++;
    if (dom !== 3'b000 || rdy !== 1'b0) begin
      mismatched++;
      $display("FAIL reqrel_run1 got=%b/%b exp=000/0", dom, rdy);
    end
    for (int e = 16; e <= 19; e++) begin
      tick;
      compared++;
      if (ack !== (e >= 19)) begin
        mismatched++;
        $display("FAIL reqrel_ack edge=%0d got=%b exp=%b",
                 e, ack, (e >= 19));
      end
    end
  endtask

  task automatic test_long_ack;
    for (int i = 1; i <= 20; i++) begin
      tick;
      compared++;
      if (ack !== 1'b1 || dom !== 3'b000 || rdy !== 1'b0) begin
        mismatched++;
        $display("FAIL longack hold=%0d got=%b/%b/%b exp=1/000/0",
                 i, ack, dom, rdy);
      end
    end
    req = 1'b0;
    tick;
    compared++;
    if (ack !== 1'b0 || dom !== 3'b000) begin
      mismatched++;
      $display("FAIL longack_drop got=%b/%b exp=0/000", ack, dom);
    end
    check_swrst_release("longack");
  endtask

  task automatic test_corners;
    logic [7:0] e8;
    do_reset;
    for (int e = 0; e <= 140; e++) begin
      tick;
      compared++;
      if (c1_dom !== (e >= 3) || c1_rdy !== (e >= 3)) begin
        mismatched++;
        $display("FAIL c1 edge=%0d got=%b/%b exp=%b",
                 e, c1_dom, c1_rdy, (e >= 3));
      end
      e8 = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (e >= 2 + 16 * (k + 1)) e8[k] = 1'b1;
      end
      compared++;
      if (c8_dom !== e8 || c8_rdy !== (e >= 130)) begin
        mismatched++;
        $display("FAIL c8 edge=%0d got=%h/%b exp=%h/%b",
                 e, c8_dom, c8_rdy, e8, (e >= 130));
      end
      compared++;
      if ((c8_dom & (c8_dom + 8'h01)) !== 8'h00) begin
        mismatched++;
        $display("FAIL c8_order edge=%0d got=%h exp=thermometer",
                 e, c8_dom);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset;
    test_powerup;
    test_swrst;
    test_async_mid;
    test_req_during_release;
    test_long_ack;
    test_corners;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer for standard-cell benchmark designs. Takes the raw active-low board reset and produces NDOM staggered, synchronously released domain resets, plus a software-reset handshake.
- Its outputs drive the buffer trees of the reset distribution network directly.
- All outputs are registered, so the downstream buffer cells see glitch-free nets.

Parameters:
- NDOM, 3: number of reset domains; minimum 1.
- SYNC, 2: synchronizer stages on nrst deassertion; minimum 2.
- DLY, 4: ck cycles between consecutive domain releases, and length of the software-reset hold; minimum 1.

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- nrst  input  1  asynchronous active-low reset. Assertion acts immediately; deassertion is synchronized internally.
- swrst_req  input  1  software reset request. Synchronous to ck; four-phase handshake.
- swrst_ack  output  1  software reset acknowledge.
- dom_nrst  output  NDOM  per-domain active-low resets; bit 0 is released first.
- ready  output  1  high when all domains are released and the block is idle.

Behaviour:
- Interface: one clock, ck. Reset is asynchronous and active-low, on port nrst.
- nrst low, at any time, in any state:
  - Immediately clears the synchronizer flops, counter and domain index.
  - Forces dom_nrst=0, ready=0, swrst_ack=0, state=HOLD.
- Synchronizer: SYNC flops, each async-cleared by nrst, shifting in constant 1. Let t0 be the first rising edge with nrst high. The last stage reads 1 after edge t0+SYNC-1.
- States: HOLD, RELEASE, RUN, SWRST, ACK.
- HOLD:
  - On an edge where the synchronizer output is 1: go to RELEASE, cnt<=0, idx<=0.
  - Therefore RELEASE is entered at edge t0+SYNC.
- RELEASE:
  - cnt increments every edge.
  - On an edge with cnt==DLY-1: dom_nrst[idx]<=1, cnt<=0, idx<=idx+1.
  - If idx==NDOM-1 on that same edge: ready<=1, state<=RUN.
  - Domain k rises at edge t0+SYNC+(k+1)*DLY. With defaults: edges t0+6, t0+10, t0+14; ready rises at t0+14.
  - swrst_req is ignored in RELEASE (and in HOLD).
- RUN:
  - On an edge sampling swrst_req=1: all dom_nrst<=0 simultaneously, ready<=0, cnt<=0, state<=SWRST.
- SWRST:
  - cnt increments every edge; swrst_req is ignored.
  - On an edge with cnt==DLY-1: swrst_ack<=1, state<=ACK.
- ACK:
  - Holds all domains in reset while swrst_req=1.
  - On an edge sampling swrst_req=0: swrst_ack<=0, cnt<=0, idx<=0, state<=RELEASE.
  - Domain 0 then rises DLY edges later; the release spacing is identical to power-up.
- Width rules:
  - cnt width is clog2(DLY) bits, with a minimum of 1 bit.
  - idx width is clog2(NDOM) bits, with a minimum of 1 bit.
  - Neither counter wraps: both are reset to 0 on every state entry that uses them.
- DLY=1 boundary: one domain is released per edge. swrst_ack rises on the edge after SWRST is entered.
- NDOM=1 boundary: ready rises on the same edge as dom_nrst[0].
- Simultaneous events:
  - nrst low overrides everything.
  - A swrst_req edge in RUN has priority over any further behaviour in that cycle.
  - A req that is already 0 when ACK is entered is sampled on the next edge.
- Invariants:
  - Once released, dom_nrst bits hold monotonically 1 until SWRST or nrst.
  - dom_nrst[k]=1 implies dom_nrst[j]=1 for all j<k.

Decomposition:
- Package rst_seq_pkg holds:
  - the state encoding localparams (HOLD=0, RELEASE=1, RUN=2, SWRST=3, ACK=4; 3-bit);
  - a clog2 helper function.
- Sub-module rst_sync (parameter SYNC; ports ck, nrst, q): the async-assert/sync-deassert flop chain. It maps one-to-one onto the library's reset flops.
- The FSM, counters and output registers live in rst_seq.

Test Plan:
- Power-up, defaults: hold nrst=0 for 3 cycles, then release -> dom_nrst stays 000 through edge t0+5. It becomes 001 at t0+6, 011 at t0+10, 111 at t0+14. ready=1 at t0+14; swrst_ack=0 throughout.
- Async reset mid-release: drop nrst 1ns after edge t0+10 -> dom_nrst=000 and ready=0 immediately, without waiting for ck. Re-release -> the full sequence repeats from HOLD with identical spacing.
- Software reset: in RUN, raise swrst_req at edge E -> dom_nrst=000 and ready=0 after E, swrst_ack=1 after E+4. Drop req; the next edge F clears ack -> dom_nrst=001 at F+4, 111 at F+12, ready=1 at F+12.
- Request during release: assert swrst_req from t0+7 to t0+12 -> the release sequence is unaffected (ready at t0+14). A req still high at RUN entry is accepted on the first RUN edge.
- Long ACK hold: keep swrst_req high for 20 cycles after ack -> swrst_ack stays 1 and dom_nrst stays 000 for the full hold. No domain is released before req=0 is sampled.
- Parameter corners:
  - NDOM=1, DLY=1, SYNC=2 -> dom_nrst=1 and ready=1 at edge t0+3.
  - NDOM=8, DLY=16 -> bit k rises at t0+2+16(k+1); verify monotonic ordering.
